// File: rtl/instruction_fetch.sv
// Fetch stage: PC, synchronous imem drive, BS/PS next-PC resolve; FETCH_STATS_EN adds fetch/flush counters.
// Latency: instruction on instr_o one cycle after its address; a taken branch inserts one NOP bubble.
// Backpressure: stall_i freezes PC, slot and memory read (imem_en_o low); branches wait for release.
module instruction_fetch #(
   parameter int              PC_W     = 8,
   parameter int              INSTR_W  = 17,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall_i,
   output logic [PC_W-1:0]    imem_addr_o,
   output logic               imem_en_o,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic [PC_W-1:0]    instr_pc_o,
   input  logic [1:0]         bs_i,
   input  logic               ps_i,
   input  logic               zero_i,
   input  logic [PC_W-1:0]    br_const_i,
   input  logic [PC_W-1:0]    br_reg_i,
`ifdef FETCH_STATS_EN
   output logic [15:0]        fetch_cnt_o,
   output logic [15:0]        flush_cnt_o,
`endif
   output logic               flush_o
);

   logic [PC_W-1:0] pc_q, pc_d;
   logic            valid_q, valid_d;
   logic [PC_W-1:0] instr_pc_q, instr_pc_d;
   logic            br_cond;
   logic            taken;
   logic [PC_W-1:0] target;

   always_comb begin
      br_cond = 1'b0;
      target  = br_const_i;
      case (bs_i)
         2'b01:   br_cond = zero_i;
         2'b10: begin
            br_cond = 1'b1;
            target  = br_reg_i;
         end
         2'b11:   br_cond = ps_i ? ~zero_i : 1'b1;
         default: br_cond = 1'b0;
      endcase
      // An empty slot carries no branch, and a stalled slot is re-evaluated on release.
      taken = valid_q & ~stall_i & br_cond;
   end

   always_comb begin
      pc_d       = pc_q;
      valid_d    = valid_q;
      instr_pc_d = instr_pc_q;
      if (!stall_i) begin
         instr_pc_d = pc_q;
         if (taken) begin
            pc_d    = target;
            valid_d = 1'b0;
         end else begin
            pc_d    = pc_q + 1'b1;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         valid_q    <= 1'b0;
         instr_pc_q <= '0;
      end else begin
         pc_q       <= pc_d;
         valid_q    <= valid_d;
         instr_pc_q <= instr_pc_d;
      end
   end

   assign imem_addr_o = pc_q;
   assign imem_en_o   = ~stall_i;
   assign instr_o     = valid_q ? imem_rdata_i : '0;
   assign instr_pc_o  = instr_pc_q;
   assign flush_o     = taken;

`ifdef FETCH_STATS_EN
   logic [15:0] fetch_cnt_q, fetch_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!stall_i && valid_q && fetch_cnt_q != 16'hFFFF)
         fetch_cnt_d = fetch_cnt_q + 16'd1;
      if (taken && flush_cnt_q != 16'hFFFF)
         flush_cnt_d = flush_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign fetch_cnt_o = fetch_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a one-cycle synchronous memory model.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_i = 1'b0;
   logic [7:0]  imem_addr_o;
   logic        imem_en_o;
   logic [16:0] imem_rdata_i = '0;
   logic [16:0] instr_o;
   logic [7:0]  instr_pc_o;
   logic [1:0]  bs_i = 2'b00;
   logic        ps_i = 1'b0;
   logic        zero_i = 1'b0;
   logic [7:0]  br_const_i = '0;
   logic [7:0]  br_reg_i = '0;
   logic        flush_o;
`ifdef FETCH_STATS_EN
   logic [15:0] fetch_cnt_o;
   logic [15:0] flush_cnt_o;
`endif

   int n_chk = 0;
   int n_err = 0;

   instruction_fetch dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall_i      (stall_i),
      .imem_addr_o  (imem_addr_o),
      .imem_en_o    (imem_en_o),
      .imem_rdata_i (imem_rdata_i),
      .instr_o      (instr_o),
      .instr_pc_o   (instr_pc_o),
      .bs_i         (bs_i),
      .ps_i         (ps_i),
      .zero_i       (zero_i),
      .br_const_i   (br_const_i),
      .br_reg_i     (br_reg_i),
`ifdef FETCH_STATS_EN
      .fetch_cnt_o  (fetch_cnt_o),
      .flush_cnt_o  (flush_cnt_o),
`endif
      .flush_o      (flush_o)
   );

   always #5 clk = ~clk;

   function automatic logic [16:0] mem_word(input logic [7:0] a);
      return {5'h0F, 4'h0, a};
   endfunction

   always @(posedge clk)
      if (imem_en_o) imem_rdata_i <= mem_word(imem_addr_o);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_slot(input string tag, input logic [7:0] pc);
      chk({tag, "_pc"}, 32'(instr_pc_o), 32'(pc));
      chk({tag, "_instr"}, 32'(instr_o), 32'(mem_word(pc)));
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, "_nop"}, 32'(instr_o), 32'h0);
      chk({tag, "_noflush"}, 32'(flush_o), 32'h0);
   endtask

   initial begin
      int guard;
      // Reset: a branch request on an empty slot must not flush.
      bs_i = 2'b11; ps_i = 1'b0;
      #12;
      chk("rst_instr", 32'(instr_o), 32'h0);
      chk("rst_flush", 32'(flush_o), 32'h0);
      chk("rst_addr", 32'(imem_addr_o), 32'h0);
      chk("rst_en", 32'(imem_en_o), 32'h1);
      chk("rst_ipc", 32'(instr_pc_o), 32'h0);
      bs_i = 2'b00;
      cyc();
      rst_n = 1'b1;
      #1;
      chk("first_cyc_nop", 32'(instr_o), 32'h0);

      // Sequential fetch 0..5.
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk_slot("seq", 8'(i));
      end

      // bs=01 taken with zero=1.
      bs_i = 2'b01; zero_i = 1'b1; br_const_i = 8'h20;
      #1 chk("bs01_flush", 32'(flush_o), 32'h1);
      cyc();
      chk_bubble("bs01_bub");
      bs_i = 2'b00;
      cyc();
      chk_slot("bs01_tgt", 8'h20);

      // bs=01 with zero=0: not taken, no bubble.
      bs_i = 2'b01; zero_i = 1'b0;
      #1 chk("bs01nt_flush", 32'(flush_o), 32'h0);
      cyc();
      chk_slot("bs01nt_next", 8'h21);

      // bs=11 ps=1 zero=0: taken.
      bs_i = 2'b11; ps_i = 1'b1; zero_i = 1'b0; br_const_i = 8'h30;
      #1 chk("bs11p1_flush", 32'(flush_o), 32'h1);
      cyc();
      bs_i = 2'b00;
      chk_bubble("bs11p1_bub");
      cyc();
      chk_slot("bs11p1_tgt", 8'h30);

      // bs=11 ps=1 zero=1: not taken.
      bs_i = 2'b11; ps_i = 1'b1; zero_i = 1'b1;
      #1 chk("bs11p1nt_flush", 32'(flush_o), 32'h0);
      cyc();
      chk_slot("bs11p1nt_next", 8'h31);

      // bs=10 register target.
      bs_i = 2'b10; br_reg_i = 8'h40; br_const_i = 8'h77;
      #1 chk("bs10_flush", 32'(flush_o), 32'h1);
      cyc();
      bs_i = 2'b00;
      chk_bubble("bs10_bub");
      cyc();
      chk_slot("bs10_tgt", 8'h40);

      // bs=11 ps=0 taken despite zero=1.
      bs_i = 2'b11; ps_i = 1'b0; zero_i = 1'b1; br_const_i = 8'h50;
      #1 chk("bs11p0_flush", 32'(flush_o), 32'h1);
      cyc();
      bs_i = 2'b00;
      chk_bubble("bs11p0_bub");
      cyc();
      chk_slot("bs11p0_tgt", 8'h50);

      // Stall while a taken branch slot is presented.
      bs_i = 2'b11; ps_i = 1'b0; br_const_i = 8'h60; stall_i = 1'b1;
      #1;
      chk("stall_flush", 32'(flush_o), 32'h0);
      chk("stall_en", 32'(imem_en_o), 32'h0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk_slot("stall_hold", 8'h50);
         chk("stall_addr", 32'(imem_addr_o), 32'h51);
         chk("stall_flush_hold", 32'(flush_o), 32'h0);
      end
      stall_i = 1'b0;
      #1;
      chk("unstall_flush", 32'(flush_o), 32'h1);
      chk("unstall_en", 32'(imem_en_o), 32'h1);
      cyc();
      bs_i = 2'b00;
      chk_bubble("unstall_bub");
      cyc();
      chk_slot("unstall_tgt", 8'h60);

      // Sequential wrap past 255 with no bubble.
      guard = 0;
      while (instr_pc_o != 8'd254 && guard < 400) begin
         cyc();
         guard++;
      end
      chk("wrap_reach", 32'(instr_pc_o), 32'd254);
      chk_slot("wrap254", 8'd254);
      cyc(); chk_slot("wrap255", 8'd255);
      cyc(); chk_slot("wrap0", 8'd0);
      cyc(); chk_slot("wrap1", 8'd1);

      // Taken branch, then reset pulsed in the bubble cycle.
      bs_i = 2'b10; br_reg_i = 8'h70;
      #1 chk("rb_flush", 32'(flush_o), 32'h1);
      cyc();
      bs_i = 2'b00;
      chk("rb_addr_tgt", 32'(imem_addr_o), 32'h70);
`ifdef FETCH_STATS_EN
      chk("flush_cnt", 32'(flush_cnt_o), 32'd6);
`endif
      rst_n = 1'b0;
      #1;
      chk("rb_addr", 32'(imem_addr_o), 32'h0);
      chk("rb_instr", 32'(instr_o), 32'h0);
      chk("rb_ipc", 32'(instr_pc_o), 32'h0);
`ifdef FETCH_STATS_EN
      chk("rb_fetch_cnt", 32'(fetch_cnt_o), 32'h0);
      chk("rb_flush_cnt", 32'(flush_cnt_o), 32'h0);
`endif
      cyc();
      rst_n = 1'b1;
      #1 chk("rb_first_nop", 32'(instr_o), 32'h0);
      cyc();
      chk_slot("rb_restart0", 8'h00);
      cyc();
      chk_slot("rb_restart1", 8'h01);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
